cache_port_seq: RTL

Per-port request sequencer sitting directly upstream of the LRU/free-list controller (`list_ctrl`). It accepts one cache access at a time from a requester and drives one `list_ctrl` port with the lookup command, or on a miss the allocate command. It performs victim writeback and line fill handshakes with memory, then returns the resolved tag to the requester. Two instances drive port0 and port1 of `list_ctrl`.

---
 rtl/cache_port_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cache_port_seq.sv
// Per-port request sequencer in front of list_ctrl: lookup, allocate with retry, victim writeback, fill.
// Optional victim writeback path is built when CACHE_PORT_WB_EN is defined.
//
// state     | meaning
// IDLE      | ready for a new access
// LOOKUP    | one-cycle lookup command to list_ctrl
// ALLOC     | one-cycle allocate command to list_ctrl
// BACKOFF   | waiting before re-issuing a blocked allocate
// WB_REQ    | dirty victim writeback request held until accepted
// WB_WAIT   | waiting for writeback completion
// FILL_REQ  | line fill request held until accepted
// FILL_WAIT | waiting for fill completion
// RESP      | one-cycle completion pulse to the requester
module cache_port_seq #(
  parameter int lists_depth = 4,
  parameter int index_lenth = 4,
  parameter int RETRY_WAIT  = 3,
  localparam int TW = (lists_depth > 1) ? $clog2(lists_depth) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic                   cpu_req_we,
  input  logic [index_lenth-1:0] cpu_req_index,
  output logic                   cpu_rsp_valid,
  output logic                   cpu_rsp_hit,
  output logic [TW-1:0]          cpu_rsp_tag,
  output logic                   acc_req,
  output logic [1:0]             acc_cmd,
  output logic [index_lenth-1:0] acc_index,
  input  logic [TW-1:0]          return_tag,
  input  logic [2:0]             acc_status,
  input  logic [index_lenth-1:0] victim_index,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_we,
  output logic [index_lenth-1:0] mem_req_index,
  input  logic                   mem_rsp_valid
);

  localparam int CW = (RETRY_WAIT > 0) ? $clog2(RETRY_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (RETRY_WAIT > 0) ? CW'(RETRY_WAIT - 1) : '0;

  typedef enum logic [3:0] {
    IDLE, LOOKUP, ALLOC, BACKOFF, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP
  } state_t;

  state_t                 state_q, state_d;
  logic                   we_q, we_d;
  logic                   hit_q, hit_d;
  logic [index_lenth-1:0] idx_q, idx_d;
  logic [index_lenth-1:0] vic_q, vic_d;
  logic [TW-1:0]          tag_q, tag_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dirty;

`ifdef CACHE_PORT_WB_EN
  assign dirty = acc_status[1];
`else
  assign dirty = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    vic_d   = vic_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (cpu_req_valid) begin
        we_d    = cpu_req_we;
        idx_d   = cpu_req_index;
        hit_d   = 1'b0;
        tag_d   = '0;
        state_d = LOOKUP;
      end
      LOOKUP: if (acc_status != 3'b000) begin
        tag_d   = return_tag;
        hit_d   = 1'b1;
        state_d = RESP;
      end else begin
        state_d = ALLOC;
      end
      ALLOC: begin
        tag_d = return_tag;
        vic_d = victim_index;
        // busy takes priority over the dirty flag of the same response
        if (acc_status[2]) begin
          if (RETRY_WAIT == 0) begin
            state_d = ALLOC;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = BACKOFF;
          end
        end else if (dirty) begin
          state_d = WB_REQ;
        end else begin
          state_d = FILL_REQ;
        end
      end
      BACKOFF: if (cnt_q == '0) state_d = ALLOC;
               else cnt_d = cnt_q - CW'(1);
`ifdef CACHE_PORT_WB_EN
      WB_REQ:  if (mem_req_ready) state_d = WB_WAIT;
      WB_WAIT: if (mem_rsp_valid) state_d = FILL_REQ;
`endif
      FILL_REQ:  if (mem_req_ready) state_d = FILL_WAIT;
      FILL_WAIT: if (mem_rsp_valid) begin
        hit_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      hit_q         <= 1'b0;
      idx_q         <= '0;
      vic_q         <= '0;
      tag_q         <= '0;
      cnt_q         <= '0;
      cpu_req_ready <= 1'b1;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_hit   <= 1'b0;
      cpu_rsp_tag   <= '0;
      acc_req       <= 1'b0;
      acc_cmd       <= 2'b00;
      acc_index     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_index <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      hit_q         <= hit_d;
      idx_q         <= idx_d;
      vic_q         <= vic_d;
      tag_q         <= tag_d;
      cnt_q         <= cnt_d;
      cpu_req_ready <= (state_d == IDLE);
      cpu_rsp_valid <= (state_d == RESP);
      cpu_rsp_hit   <= (state_d == RESP) && hit_d;
      cpu_rsp_tag   <= (state_d == RESP) ? tag_d : '0;
      acc_req       <= (state_d == LOOKUP) || (state_d == ALLOC);
      acc_cmd       <= (state_d == ALLOC)  ? 2'b10 :
                       (state_d == LOOKUP) ? {1'b0, we_d} : 2'b00;
      acc_index     <= ((state_d == LOOKUP) || (state_d == ALLOC)) ? idx_d : '0;
      mem_req_valid <= (state_d == WB_REQ) || (state_d == FILL_REQ);
      mem_req_index <= (state_d == WB_REQ)   ? vic_d :
                       (state_d == FILL_REQ) ? idx_d : '0;
    end
  end

`ifdef CACHE_PORT_WB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_req_we <= 1'b0;
    else        mem_req_we <= (state_d == WB_REQ);
  end
`else
  assign mem_req_we = 1'b0;
`endif

endmodule
